weighted_symbol_sampler: RTL

Parametrised successor to the four-nucleotide random generator. It draws a stream of `LENGTH` symbols from `NUM_CAT` categories according to run-time integer weights. Sampling is unbiased: rejection is applied both to the modulus and to the unallocated weight range. Output uses a valid/ready handshake. The block sits between the substitution-model weight registers and the sequence writer in the simulation datapath.

---
 rtl/sampler_pkg.sv | 19 +
 rtl/weighted_symbol_sampler_lfsr16.sv | 21 ++
 rtl/weighted_symbol_sampler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the weighted symbol sampler: FSM states,
// the 16-bit Galois LFSR polynomial and its step function.
package sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/weighted_symbol_sampler_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances on every clock out of reset.
module lfsr16
  import sampler_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] state_o
);

  logic [15:0] state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= lfsr_step(state_q);
  end

  assign state_o = state_q;

endmodule

// File: rtl/weighted_symbol_sampler.sv
// Draws a run of symbols from NUM_CAT categories by rejection sampling an LFSR
// candidate against registered prefix sums of the run-time weights.
module weighted_symbol_sampler
  import sampler_pkg::*;
#(
  parameter int          NUM_CAT = 4,
  parameter int          W       = 10,
  parameter int          TOTAL   = 1000,
  parameter logic [15:0] SEED    = DEFAULT_SEED,
  localparam int         CW      = $clog2(NUM_CAT),
  localparam int         RW      = $clog2(TOTAL)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  input  logic [NUM_CAT*W-1:0] cfg_weights,
  output logic                 cfg_ready,
  input  logic                 start,
  input  logic [15:0]          length,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_sym,
  output logic                 out_last,
  output logic                 cfg_err,
  output logic [1:0]           dbg_state,
  output logic [15:0]          dbg_lfsr
);

  localparam int PW   = W + CW;
  localparam int CMPW = (PW > RW) ? PW : RW;

  state_e               state_q;
  logic [NUM_CAT*W-1:0] w_q;
  logic [PW-1:0]        psum_q [NUM_CAT];
  logic [PW-1:0]        psum_d [NUM_CAT];
  logic                 cfg_ok_q, cfg_err_q;
  logic [15:0]          len_q, count_q, count_d;
  logic                 out_valid_q, out_last_q;
  logic [CW-1:0]        out_sym_q;
  logic [15:0]          lfsr;
  logic [CMPW-1:0]      cand;
  logic                 accept, sum_bad, handshake, draw_slot;
  logic [CW-1:0]        hit_sym;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state_o (lfsr)
  );

  always_comb begin
    logic [PW-1:0] acc;
    acc = '0;
    for (int k = 0; k < NUM_CAT; k++) begin
      acc       = acc + PW'(w_q[k*W +: W]);
      psum_d[k] = acc;
    end
  end

  assign sum_bad = (psum_d[NUM_CAT-1] == '0) ||
                   (32'(psum_d[NUM_CAT-1]) > 32'(TOTAL));

  // Candidates past the final prefix sum cover both r >= TOTAL and unallocated weight.
  assign cand   = CMPW'(lfsr[RW-1:0]);
  assign accept = cand < CMPW'(psum_q[NUM_CAT-1]);

  always_comb begin
    hit_sym = '0;
    for (int k = NUM_CAT - 1; k >= 0; k--) begin
      if (cand < CMPW'(psum_q[k])) hit_sym = CW'(k);
    end
  end

  // out_valid/out_ready: a symbol transfers on any rising edge where both are
  // high; while out_valid && !out_ready the symbol and last flag are held.
  assign handshake = out_valid_q && out_ready;
  assign draw_slot = (state_q == ST_RUN) && (!out_valid_q || (out_ready && !out_last_q));
  assign count_d   = count_q + {15'd0, handshake};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      for (int k = 0; k < NUM_CAT; k++) psum_q[k] <= '0;
      cfg_ok_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      len_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sym_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            w_q     <= cfg_weights;
            state_q <= ST_LOAD;
          end else if (start && cfg_ok_q && (length != 16'd0)) begin
            len_q   <= length;
            count_q <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_LOAD: begin
          for (int k = 0; k < NUM_CAT; k++) psum_q[k] <= psum_d[k];
          cfg_err_q <= sum_bad;
          cfg_ok_q  <= !sum_bad;
          state_q   <= ST_IDLE;
        end
        ST_RUN: begin
          count_q <= count_d;
          if (handshake && out_last_q) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (draw_slot) begin
            if (accept) begin
              out_valid_q <= 1'b1;
              out_sym_q   <= hit_sym;
              out_last_q  <= (count_d == (len_q - 16'd1));
            end else if (handshake) begin
              out_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state_q;
  assign dbg_lfsr  = lfsr;

endmodule
